// File: rtl/parking_gate_controller.sv
// Parking gate controller: entry and exit barrier FSMs feeding a parking counter.
// Latency: sensor sampled on edge 1, barrier opens on edge 2; event pulse one cycle after pass.
// Backpressure: exit report waits one cycle when the entry report owns the same cycle.
//
// Ports:
//   clk, rst                                   single clock, async active-high reset
//   entry_sensor / entry_card_uni / entry_pass car waiting, its class, and barrier cleared at entry
//   exit_sensor  / exit_card_uni  / exit_pass  same meanings at the exit barrier
//   uni_is_vacated_space, is_vacated_space     vacancy flags per class from the counter
//   car_entered / is_uni_car_entered           one-cycle entry event and its class
//   car_exited  / is_uni_car_exited            one-cycle exit event and its class
//   entry_gate_open, exit_gate_open            barrier drives
//   entry_deny                                 "full" light at entry
//   entry_timeout                              one-cycle pulse when either barrier times out
//   deny_count                                 saturating count of refused entries
module parking_gate_controller #(
  parameter int GATE_TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_sensor,
  input  logic       entry_card_uni,
  input  logic       entry_pass,
  input  logic       exit_sensor,
  input  logic       exit_card_uni,
  input  logic       exit_pass,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_deny,
  output logic       entry_timeout,
  output logic [7:0] deny_count
);

  typedef enum logic [2:0] {
    E_IDLE,
    E_CHECK,
    E_OPEN,
    E_REPORT,
    E_DENY,
    E_WAIT_CLEAR
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_OPEN,
    X_REPORT,
    X_WAIT_CLEAR
  } exit_state_t;

  // Last timer value at which an open barrier is still allowed to stay open.
  localparam logic [7:0] TIMER_LAST = 8'(GATE_TIMEOUT - 1);

  entry_state_t e_state_q, e_state_d;
  exit_state_t  x_state_q, x_state_d;
  logic [7:0]   e_timer_q, e_timer_d;
  logic [7:0]   x_timer_q, x_timer_d;
  logic         e_class_q, e_class_d;
  logic         x_class_q, x_class_d;
  logic [7:0]   deny_count_q, deny_count_d;
  logic         timeout_q, timeout_d;
  logic         e_timeout_fire;
  logic         x_timeout_fire;
  logic         vacancy_ok;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_state_q    <= E_IDLE;
      x_state_q    <= X_IDLE;
      e_timer_q    <= 8'd0;
      x_timer_q    <= 8'd0;
      e_class_q    <= 1'b0;
      x_class_q    <= 1'b0;
      deny_count_q <= 8'd0;
      timeout_q    <= 1'b0;
    end else begin
      e_state_q    <= e_state_d;
      x_state_q    <= x_state_d;
      e_timer_q    <= e_timer_d;
      x_timer_q    <= x_timer_d;
      e_class_q    <= e_class_d;
      x_class_q    <= x_class_d;
      deny_count_q <= deny_count_d;
      timeout_q    <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    e_state_d      = e_state_q;
    e_timer_d      = e_timer_q;
    e_class_d      = e_class_q;
    deny_count_d   = deny_count_q;
    e_timeout_fire = 1'b0;
    // Vacancy is judged against the class latched when the car arrived.
    vacancy_ok     = e_class_q ? uni_is_vacated_space : is_vacated_space;

    case (e_state_q)
      E_IDLE: begin
        if (entry_sensor) begin
          e_state_d = E_CHECK;
          e_class_d = entry_card_uni;
        end
      end

      E_CHECK: begin
        if (vacancy_ok) begin
          e_state_d = E_OPEN;
          e_timer_d = 8'd0;
        end else begin
          e_state_d = E_DENY;
          if (deny_count_q != 8'hFF) begin
            deny_count_d = deny_count_q + 8'd1;
          end
        end
      end

      E_OPEN: begin
        // A pass in the final open cycle still counts as a car, not a timeout.
        if (entry_pass) begin
          e_state_d = E_REPORT;
        end else if (e_timer_q == TIMER_LAST) begin
          e_state_d      = E_WAIT_CLEAR;
          e_timeout_fire = 1'b1;
        end else begin
          e_timer_d = e_timer_q + 8'd1;
        end
      end

      // Always passes through E_WAIT_CLEAR so the counter has updated the
      // vacancy flags before the next car is checked.
      E_REPORT: e_state_d = E_WAIT_CLEAR;

      E_DENY, E_WAIT_CLEAR: begin
        if (!entry_sensor) begin
          e_state_d = E_IDLE;
        end
      end

      default: e_state_d = E_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Exit FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    x_state_d      = x_state_q;
    x_timer_d      = x_timer_q;
    x_class_d      = x_class_q;
    x_timeout_fire = 1'b0;

    case (x_state_q)
      X_IDLE: begin
        if (exit_sensor) begin
          x_state_d = X_OPEN;
          x_class_d = exit_card_uni;
          x_timer_d = 8'd0;
        end
      end

      X_OPEN: begin
        if (exit_pass) begin
          x_state_d = X_REPORT;
        end else if (x_timer_q == TIMER_LAST) begin
          x_state_d      = X_WAIT_CLEAR;
          x_timeout_fire = 1'b1;
        end else begin
          x_timer_d = x_timer_q + 8'd1;
        end
      end

      // The counter takes one event per cycle; entry wins, exit holds here one
      // extra cycle. E_REPORT never lasts two cycles, so the deferral is bounded.
      X_REPORT: begin
        if (e_state_q != E_REPORT) begin
          x_state_d = X_WAIT_CLEAR;
        end
      end

      X_WAIT_CLEAR: begin
        if (!exit_sensor) begin
          x_state_d = X_IDLE;
        end
      end

      default: x_state_d = X_IDLE;
    endcase
  end

  assign timeout_d = e_timeout_fire | x_timeout_fire;

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign entry_gate_open    = (e_state_q == E_OPEN);
  assign entry_deny         = (e_state_q == E_DENY);
  assign car_entered        = (e_state_q == E_REPORT);
  assign is_uni_car_entered = car_entered & e_class_q;

  assign exit_gate_open     = (x_state_q == X_OPEN);
  assign car_exited         = (x_state_q == X_REPORT) && (e_state_q != E_REPORT);
  assign is_uni_car_exited  = car_exited & x_class_q;

  assign entry_timeout      = timeout_q;
  assign deny_count         = deny_count_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
module tb_parking_gate_controller;

  logic       clk;
  logic       rst;
  logic       entry_sensor;
  logic       entry_card_uni;
  logic       entry_pass;
  logic       exit_sensor;
  logic       exit_card_uni;
  logic       exit_pass;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       entry_deny;
  logic       entry_timeout;
  logic [7:0] deny_count;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: bit1 = exit event, bit0 = university class.
  logic [1:0] exp_q[$];
  logic [1:0] sb_exp;

  parking_gate_controller #(.GATE_TIMEOUT(20)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .entry_sensor         (entry_sensor),
    .entry_card_uni       (entry_card_uni),
    .entry_pass           (entry_pass),
    .exit_sensor          (exit_sensor),
    .exit_card_uni        (exit_card_uni),
    .exit_pass            (exit_pass),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
    .entry_deny           (entry_deny),
    .entry_timeout        (entry_timeout),
    .deny_count           (deny_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every event pulse pops one expected event.
  always @(negedge clk) begin
    if (!rst && (car_entered || car_exited)) begin
      chk("no_overlap", {31'd0, car_entered & car_exited}, 32'd0);
      if (car_entered) begin
        chk("sb_entry_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          sb_exp = exp_q.pop_front();
          chk("sb_entry", {30'd0, 1'b0, is_uni_car_entered}, {30'd0, sb_exp});
        end
      end
      if (car_exited) begin
        chk("sb_exit_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          sb_exp = exp_q.pop_front();
          chk("sb_exit", {30'd0, 1'b1, is_uni_car_exited}, {30'd0, sb_exp});
        end
      end
    end
  end

  initial begin
    int n;
    logic to_seen;

    rst                  = 1'b1;
    entry_sensor         = 1'b0;
    entry_card_uni       = 1'b0;
    entry_pass           = 1'b0;
    exit_sensor          = 1'b0;
    exit_card_uni        = 1'b0;
    exit_pass            = 1'b0;
    uni_is_vacated_space = 1'b0;
    is_vacated_space     = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_entry_gate", {31'd0, entry_gate_open}, 32'd0);
    chk("rst_exit_gate",  {31'd0, exit_gate_open},  32'd0);
    chk("rst_deny",       {31'd0, entry_deny},      32'd0);
    chk("rst_timeout",    {31'd0, entry_timeout},   32'd0);
    chk("rst_deny_count", {24'd0, deny_count},      32'd0);
    chk("rst_events",     {30'd0, car_entered, car_exited}, 32'd0);
    rst = 1'b0;
    tick();

    // Public entry with vacancy
    is_vacated_space     = 1'b1;
    uni_is_vacated_space = 1'b1;
    entry_sensor         = 1'b1;
    entry_card_uni       = 1'b0;
    tick();
    chk("pub_gate_edge1", {31'd0, entry_gate_open}, 32'd0);
    tick();
    chk("pub_gate_edge2", {31'd0, entry_gate_open}, 32'd1);
    entry_pass = 1'b1;
    exp_q.push_back(2'b00);
    tick();
    entry_pass   = 1'b0;
    entry_sensor = 1'b0;
    chk("pub_car_entered", {31'd0, car_entered},        32'd1);
    chk("pub_is_uni",      {31'd0, is_uni_car_entered}, 32'd0);
    chk("pub_gate_closed", {31'd0, entry_gate_open},    32'd0);
    tick();
    chk("pub_entered_once", {31'd0, car_entered}, 32'd0);
    tick();

    // University entry: class latched on the sensor edge
    entry_sensor   = 1'b1;
    entry_card_uni = 1'b1;
    tick();
    entry_card_uni = 1'b0;
    tick();
    chk("uni_gate_open", {31'd0, entry_gate_open}, 32'd1);
    entry_pass = 1'b1;
    exp_q.push_back(2'b01);
    tick();
    entry_pass   = 1'b0;
    entry_sensor = 1'b0;
    chk("uni_is_uni", {31'd0, is_uni_car_entered}, 32'd1);
    repeat (2) tick();

    // University full: denied, pass ignored, count increments once
    uni_is_vacated_space = 1'b0;
    entry_card_uni       = 1'b1;
    entry_sensor         = 1'b1;
    tick();
    tick();
    chk("full_deny",       {31'd0, entry_deny},      32'd1);
    chk("full_gate",       {31'd0, entry_gate_open}, 32'd0);
    chk("full_deny_count", {24'd0, deny_count},      32'd1);
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    tick();
    chk("full_deny_hold",  {31'd0, entry_deny},      32'd1);
    chk("full_count_hold", {24'd0, deny_count},      32'd1);
    chk("full_gate_hold",  {31'd0, entry_gate_open}, 32'd0);
    entry_sensor = 1'b0;
    tick();
    chk("full_deny_clear", {31'd0, entry_deny}, 32'd0);

    // Timeout: open exactly 20 cycles, one timeout pulse, no event
    uni_is_vacated_space = 1'b1;
    entry_card_uni       = 1'b0;
    entry_sensor         = 1'b1;
    tick();
    tick();
    chk("to_gate_open", {31'd0, entry_gate_open}, 32'd1);
    n       = 0;
    to_seen = 1'b0;
    while (entry_gate_open && n < 40) begin
      to_seen = to_seen | entry_timeout;
      n++;
      tick();
    end
    chk("to_open_cycles",  n,                         32'd20);
    chk("to_early_pulse",  {31'd0, to_seen},          32'd0);
    chk("to_pulse",        {31'd0, entry_timeout},    32'd1);
    chk("to_no_entered",   {31'd0, car_entered},      32'd0);
    tick();
    chk("to_pulse_once",   {31'd0, entry_timeout},    32'd0);
    entry_sensor = 1'b0;
    repeat (2) tick();

    // Collision: both passes in the same cycle
    entry_sensor   = 1'b1;
    entry_card_uni = 1'b0;
    exit_sensor    = 1'b1;
    exit_card_uni  = 1'b1;
    tick();
    tick();
    chk("col_both_open", {30'd0, entry_gate_open, exit_gate_open}, 32'd3);
    entry_pass = 1'b1;
    exit_pass  = 1'b1;
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    tick();
    entry_pass   = 1'b0;
    exit_pass    = 1'b0;
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    chk("col_n1_events",  {30'd0, car_entered, car_exited}, 32'd2);
    chk("col_exit_gate",  {31'd0, exit_gate_open},          32'd0);
    tick();
    chk("col_n2_events",  {30'd0, car_entered, car_exited}, 32'd1);
    chk("col_exit_uni",   {31'd0, is_uni_car_exited},       32'd1);
    tick();
    chk("col_exit_once",  {31'd0, car_exited}, 32'd0);
    tick();

    // Reset while the exit barrier is open: closes without a clock edge
    exit_sensor   = 1'b1;
    exit_card_uni = 1'b0;
    tick();
    chk("rmo_open", {31'd0, exit_gate_open}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmo_closed_async", {31'd0, exit_gate_open}, 32'd0);
    chk("rmo_deny_count",   {24'd0, deny_count},     32'd0);
    exit_sensor = 1'b0;
    #2;
    rst = 1'b0;
    exit_pass = 1'b1;
    tick();
    exit_pass = 1'b0;
    repeat (3) tick();
    chk("rmo_gate_stays", {31'd0, exit_gate_open}, 32'd0);

    // Saturation: 260 refused public entries
    is_vacated_space = 1'b0;
    entry_card_uni   = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      entry_sensor = 1'b1;
      tick();
      tick();
      if (i == 1)   chk("sat_count_1",   {24'd0, deny_count}, 32'd1);
      if (i == 255) chk("sat_count_255", {24'd0, deny_count}, 32'd255);
      entry_sensor = 1'b0;
      tick();
    end
    chk("sat_count_260", {24'd0, deny_count}, 32'd255);
    chk("sat_deny_idle", {31'd0, entry_deny}, 32'd0);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
